// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte-stream requesters, packet-locked.
// Optional tag byte per packet when UART_ARB_TAG_EN is defined.
module uart_tx_arbiter #(
  parameter int                NUM_REQ  = 4,
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] TAG_BASE = 8'hF0
) (
  input  logic                      CLK100MHZ,
  input  logic                      ck_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      active,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
`ifdef UART_ARB_TAG_EN
  localparam logic [2:0] S_TAG       = 3'd1;
`endif
  localparam logic [2:0] S_FETCH     = 3'd2;
  localparam logic [2:0] S_START     = 3'd3;
  localparam logic [2:0] S_WAIT_ACK  = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;

  logic [2:0]        state;
  logic [IDX_W-1:0]  last_idx;
  logic              last_flag;

  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  int                cand;

  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  // Scan downward in distance so the nearest valid requester after last_idx wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(last_idx) + k) % NUM_REQ;
      if (req_valid[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  // last_idx doubles as the index of the current owner while a packet is active.
  assign sel_valid = req_valid[last_idx];
  assign sel_last  = req_last[last_idx];
  assign sel_data  = req_data[int'(last_idx)*DATA_W +: DATA_W];

  assign req_ready = (state == S_FETCH) ? grant : '0;
  assign tx_start  = (state == S_START);
  assign active    = (state != S_IDLE);

  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      state     <= S_IDLE;
      last_idx  <= IDX_W'(NUM_REQ - 1);
      grant     <= '0;
      tx_data   <= '0;
      last_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant    <= idx_to_onehot(pick_idx);
            last_idx <= pick_idx;
`ifdef UART_ARB_TAG_EN
            state    <= S_TAG;
`else
            state    <= S_FETCH;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        S_TAG: begin
          tx_data   <= TAG_BASE | DATA_W'(last_idx);
          last_flag <= 1'b0;
          state     <= S_START;
        end
`endif
        S_FETCH: begin
          if (sel_valid) begin
            tx_data   <= sel_data;
            last_flag <= sel_last;
            state     <= S_START;
          end
        end
        S_START: state <= S_WAIT_ACK;
        S_WAIT_ACK: begin
          if (tx_busy) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_flag) begin
              grant <= '0;
              state <= S_IDLE;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple transmitter model.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int LIMIT = 300;

  logic            CLK100MHZ = 1'b0;
  logic            ck_rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    grant;
  logic            active;
  logic [W-1:0]    tx_data;
  logic            tx_start;
  logic            tx_busy = 1'b0;
  int              busy_cnt = 0;

  int n_checks = 0;
  int n_fail = 0;
  int pulse_err = 0;
  logic prev_start = 1'b0;
  logic [7:0] log_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [N-1:0] valid;
    int           exp_idx;
  } rr_vec_t;
  rr_vec_t vecs[10];

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .TAG_BASE(8'hF0)) dut (
    .CLK100MHZ(CLK100MHZ), .ck_rst(ck_rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .grant(grant), .active(active),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  // Transmitter: busy rises the cycle after start and stays high for 10 cycles.
  always @(posedge CLK100MHZ) begin
    if (tx_start) begin
      tx_busy  <= 1'b1;
      busy_cnt <= 10;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt <= 0;
      tx_busy  <= 1'b0;
    end
  end

  always @(negedge CLK100MHZ) begin
    if (tx_start) begin
      log_q.push_back(tx_data);
      if (prev_start) pulse_err <= pulse_err + 1;
    end
    prev_start <= tx_start;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic wait_grant();
    int c = 0;
    while (grant == '0 && c < LIMIT) begin @(negedge CLK100MHZ); c++; end
    if (grant == '0) check("wait_grant_timeout", 32'(c), 32'(0));
  endtask

  task automatic wait_xfer();
    int c = 0;
    while ((req_ready & req_valid) == '0 && c < LIMIT) begin @(negedge CLK100MHZ); c++; end
    if ((req_ready & req_valid) == '0) check("wait_xfer_timeout", 32'(c), 32'(0));
  endtask

  task automatic wait_idle();
    int c = 0;
    while (active && c < LIMIT) begin @(negedge CLK100MHZ); c++; end
    if (active) check("wait_idle_timeout", 32'(c), 32'(0));
  endtask

  task automatic wait_ready(input logic [N-1:0] r);
    int c = 0;
    while (req_ready != r && c < LIMIT) begin @(negedge CLK100MHZ); c++; end
    if (req_ready != r) check("wait_ready_timeout", 32'(c), 32'(0));
  endtask

  task automatic expect_tag(input int idx);
`ifdef UART_ARB_TAG_EN
    exp_q.push_back(8'hF0 | 8'(idx));
`else
    if (idx < 0) exp_q.push_back(8'h00);
`endif
  endtask

  task automatic check_log(input string name);
    check({name, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check({name, "_byte"}, 32'(log_q[i]), 32'(exp_q[i]));
  endtask

  task automatic set_lane(input int i, input logic [7:0] d);
    req_data[i*W +: W] = d;
  endtask

  initial begin
    vecs[0] = '{4'b1111, 1};
    vecs[1] = '{4'b1111, 2};
    vecs[2] = '{4'b1111, 3};
    vecs[3] = '{4'b1111, 0};
    vecs[4] = '{4'b0001, 0};
    vecs[5] = '{4'b1001, 3};
    vecs[6] = '{4'b1001, 0};
    vecs[7] = '{4'b0110, 1};
    vecs[8] = '{4'b0101, 2};
    vecs[9] = '{4'b0010, 1};

    // Reset with every requester valid.
    ck_rst    = 1'b0;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int i = 0; i < N; i++) set_lane(i, 8'(8'h30 + i));
    repeat (3) @(negedge CLK100MHZ);
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_ready", 32'(req_ready), 32'(0));
    check("rst_active", 32'(active), 32'(0));
    check("rst_tx_start", 32'(tx_start), 32'(0));
    check("rst_tx_data", 32'(tx_data), 32'(0));
    log_q.delete(); exp_q.delete();
    ck_rst = 1'b1;
    wait_grant();
    check("first_grant", 32'(grant), 32'(4'b0001));
`ifndef UART_ARB_TAG_EN
    check("first_ready", 32'(req_ready), 32'(4'b0001));
`endif
    wait_xfer();
    @(posedge CLK100MHZ); #1 req_valid = '0;
`ifndef UART_ARB_TAG_EN
    @(negedge CLK100MHZ);
    check("first_start_latency", 32'(tx_start), 32'(1));
    check("first_start_data", 32'(tx_data), 32'(8'h30));
`endif
    wait_idle();
    expect_tag(0); exp_q.push_back(8'h30);
    check_log("first_pkt");

    // Round-robin arbitration table.
    for (int k = 0; k < 10; k++) begin
      log_q.delete(); exp_q.delete();
      for (int i = 0; i < N; i++) set_lane(i, 8'((k + 1) * 16 + i));
      req_last  = '1;
      req_valid = vecs[k].valid;
      wait_grant();
      check($sformatf("rr_grant_%0d", k), 32'(grant), 32'(4'b0001 << vecs[k].exp_idx));
      wait_xfer();
      @(posedge CLK100MHZ); #1 req_valid = '0;
      wait_idle();
      expect_tag(vecs[k].exp_idx);
      exp_q.push_back(8'((k + 1) * 16 + vecs[k].exp_idx));
      check_log($sformatf("rr_log_%0d", k));
    end

    // Two-byte packet from requester 2.
    log_q.delete(); exp_q.delete();
    set_lane(2, 8'h41); req_last = 4'b0000; req_valid = 4'b0100;
    wait_grant();
    check("single_grant", 32'(grant), 32'(4'b0100));
    wait_xfer();
    @(posedge CLK100MHZ); #1 set_lane(2, 8'h42); req_last = 4'b0100;
    wait_xfer();
    @(posedge CLK100MHZ); #1 req_valid = '0; req_last = '0;
    wait_idle();
    check("single_grant_cleared", 32'(grant), 32'(0));
    expect_tag(2); exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    check_log("single_pkt");

    // Packet lock: requester 1 stalls between bytes while requester 3 waits.
    log_q.delete(); exp_q.delete();
    set_lane(1, 8'h51); set_lane(3, 8'h73); req_last = 4'b1000; req_valid = 4'b0010;
    wait_grant();
    check("lock_grant", 32'(grant), 32'(4'b0010));
    wait_xfer();
    @(posedge CLK100MHZ); #1 req_valid = 4'b1000;
    wait_ready(4'b0010);
    begin
      int bad_grant = 0;
      int starts = 0;
      repeat (20) begin
        @(negedge CLK100MHZ);
        if (grant != 4'b0010) bad_grant++;
        if (tx_start) starts++;
      end
      check("lock_grant_held", 32'(bad_grant), 32'(0));
      check("lock_no_start", 32'(starts), 32'(0));
    end
    set_lane(1, 8'h52); req_last = 4'b1010; req_valid = 4'b1010;
    wait_xfer();
    @(posedge CLK100MHZ); #1 req_valid = 4'b1000;
    wait_idle();
    expect_tag(1); exp_q.push_back(8'h51); exp_q.push_back(8'h52);
    check_log("lock_pkt1");
    wait_grant();
    check("lock_next_grant", 32'(grant), 32'(4'b1000));
    wait_xfer();
    @(posedge CLK100MHZ); #1 req_valid = '0;
    wait_idle();
    expect_tag(3); exp_q.push_back(8'h73);
    check_log("lock_pkt3");

    // Reset during WAIT_DONE of the first byte of a three-byte packet.
    log_q.delete(); exp_q.delete();
    set_lane(0, 8'h61); req_last = '0; req_valid = 4'b0001;
    wait_grant();
    check("mid_grant", 32'(grant), 32'(4'b0001));
    wait_xfer();
    @(posedge CLK100MHZ); #1 set_lane(0, 8'h62);
    begin
      int c = 0;
      while (!tx_busy && c < LIMIT) begin @(negedge CLK100MHZ); c++; end
      check("mid_busy_seen", 32'(tx_busy), 32'(1));
    end
    @(negedge CLK100MHZ);
    check("mid_active_before", 32'(active), 32'(1));
    ck_rst = 1'b0;
    #1;
    check("mid_rst_tx_start", 32'(tx_start), 32'(0));
    check("mid_rst_grant", 32'(grant), 32'(0));
    check("mid_rst_ready", 32'(req_ready), 32'(0));
    check("mid_rst_active", 32'(active), 32'(0));
    req_valid = '0;
    repeat (3) @(negedge CLK100MHZ);
    ck_rst = 1'b1;
    repeat (30) @(negedge CLK100MHZ);
    check("mid_idle_grant", 32'(grant), 32'(0));
    expect_tag(0); exp_q.push_back(8'h61);
    check_log("mid_partial");
    set_lane(0, 8'h71); req_last = 4'b0001; req_valid = 4'b0001;
    wait_grant();
    check("mid_restart_grant", 32'(grant), 32'(4'b0001));
    wait_xfer();
    @(posedge CLK100MHZ); #1 req_valid = '0;
    wait_idle();
    expect_tag(0); exp_q.push_back(8'h71);
    check_log("mid_restart");

    check("start_pulse_width", 32'(pulse_err), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter of the Arty UART controller between `NUM_REQ` byte-stream requesters. It grants the transmitter to one requester for a whole packet, which ends at the byte flagged `req_last`. It then sequences each byte into the transmitter through a start/busy handshake. The block sits between the controller's internal message sources and the UART TX core, in the `CLK100MHZ` domain.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: byte width.
- `TAG_BASE`, 8'hF0: upper bits of the tag byte; used only with the tag feature.

- `CLK100MHZ`  in  1  system clock; all logic is rising-edge.
- `ck_rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  requester i has a byte on its data lane.
- `req_last`  in  NUM_REQ  that byte ends requester i's packet.
- `req_data`  in  NUM_REQ*DATA_W  requester i's byte at `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  NUM_REQ  byte accepted from requester i; a transfer happens on `valid && ready`.
- `grant`  out  NUM_REQ  one-hot owner of the transmitter; all zero when idle.
- `active`  out  1  a packet is in progress.
- `tx_data`  out  DATA_W  byte to the transmitter; stable from `tx_start` until `tx_busy` falls.
- `tx_start`  out  1  one-cycle start pulse.
- `tx_busy`  in  1  transmitter frame in progress; rises ≤1 cycle after `tx_start` and stays high until the frame ends.

## Operation
- States: IDLE, TAG, FETCH, START, WAIT_ACK, WAIT_DONE.
- **IDLE:** if any `req_valid` is high, pick the first set bit searching upward, with wrap, from `last_idx+1`. Register `grant` and `last_idx`, then go to TAG if the tag feature is enabled, else FETCH. With none valid, stay in IDLE.
- **FETCH:**
  - `req_ready[g]`=1; `ready` depends only on state and `grant`, never combinationally on `req_valid`.
  - On `req_valid[g]`, latch the byte into `tx_data` and latch `req_last[g]`, then go to START.
  - Otherwise hold FETCH and keep the grant (packet lock).
- **START:** `tx_start`=1 for exactly one cycle, then go to WAIT_ACK.
- **WAIT_ACK:** wait for `tx_busy`=1, then go to WAIT_DONE. If `tx_busy` is already high during START, WAIT_ACK lasts one cycle.
- **WAIT_DONE:** wait for `tx_busy`=0.
  - If the latched last flag is set: clear `grant`, go to IDLE.
  - Otherwise: go to FETCH.
- **TAG:** `tx_data` = `TAG_BASE | g`, then START, WAIT_ACK and WAIT_DONE as above, then FETCH. The last flag is forced to 0 for the tag byte.
- Requesters other than `g` see `req_ready`=0 at all times.
- **Fairness:** after a packet from i, every other requester that is valid at the next IDLE is served before i again.
- **Stuck transmitter:** there is no timeout. If `tx_busy` never rises or never falls, the block waits indefinitely.
- **Reset mid-packet:** all state is dropped and the partial packet is lost. The requester must restart the packet.

## Timing
- **Reset values:** `grant`=0, `active`=0, `req_ready`=0, `tx_start`=0, `tx_data`=0, state IDLE, `last_idx`=NUM_REQ-1 (so requester 0 wins first).
- `active` = (state != IDLE).
- **Latency without tag:**
  - `req_valid` high in IDLE cycle n.
  - `grant` and `req_ready` high at n+1; transfer at n+1.
  - `tx_start` at n+2.
- **Byte-to-byte within a packet:** FETCH is re-entered the cycle after `tx_busy` falls. The next `tx_start` follows 1 cycle after the transfer.
- **Packet to packet:** the cycle after the final `tx_busy` fall is IDLE. The new `grant` appears in the following cycle.
- **Simultaneous requests:** all are resolved in one IDLE cycle by the round-robin pointer.

## Configuration
- `UART_ARB_TAG_EN` defined: each packet is prefixed by one tag byte `TAG_BASE | idx`. Without tag, latency to the first data `tx_start` is n+2; with tag it grows by one tag frame plus 2 cycles.
- Not defined: the TAG state and the tag logic are absent. IDLE goes directly to FETCH.

## Test plan
- **Reset:** `ck_rst`=0 while `req_valid`=4'b1111, then release.
  - During reset, all outputs are 0.
  - The first grant is 4'b0001.
- **Single packet:** requester 2 sends 8'h41, 8'h42 (last). Transmitter model raises busy 1 cycle after start and holds it 10 cycles.
  - Without tag: exactly two `tx_start` pulses, with `tx_data` 8'h41 then 8'h42; `grant` returns to 0.
  - With `UART_ARB_TAG_EN`: first byte 8'hF2, then 8'h41, 8'h42.
- **Round-robin:** all four requesters hold 1-byte last packets continuously.
  - Grant order 0,1,2,3,0.
  - No requester is served twice within any 4 packets.
- **Packet lock:** requester 1 drops `req_valid` for 20 cycles between bytes while requester 3 is valid.
  - `grant` stays 4'b0010 and no `tx_start` is issued.
  - Requester 1's bytes complete before requester 3 is granted.
- **Reset mid-packet:** assert `ck_rst` during WAIT_DONE of the first byte of a 3-byte packet.
  - `tx_start`, `grant` and `req_ready` go to 0 immediately.
  - After release, no remaining byte is sent until a new request arrives.
